// File: rtl/mult_pkg.sv
// mult_pkg: shared types and constants for the shift-add multiplier scheduler.
//   state_t   - scheduler FSM state encoding (3 bits)
//   DEF_WIDTH - default operand width
//   DEF_NREQ  - default number of requesters
//   MULT_LAT  - cycles from the request handshake to the first rsp_valid
package mult_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_NREQ  = 2;
  localparam int MULT_LAT  = 2 * DEF_WIDTH + 3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_ADD     = 3'd2,
    ST_SHIFT   = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_RESP    = 3'd5
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: NREQ-wide round-robin arbiter.
//   Clk, Reset_n - clock, asynchronous active-low reset
//   en           - grants are produced only while en is high
//   req          - request vector
//   advance      - move the pointer to the current winner (accepted handshake)
//   grant        - one-hot winner, all-zero when nothing requests or en is low
//   grant_idx    - index of the winner
// The search starts one past the last winner, so the reset pointer value of
// NREQ-1 gives requester 0 first priority.
module rr_arbiter
  import mult_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic            Clk,
  input  logic            Reset_n,
  input  logic            en,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   grant_idx
);

  logic [IW-1:0] ptr_q;
  logic          found;
  int            c;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ptr_q <= IW'(NREQ - 1);
    end else if (advance) begin
      ptr_q <= grant_idx;
    end
  end

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    c         = 0;
    for (int k = 1; k <= NREQ; k++) begin
      // Wrap the candidate index without a general modulo.
      c = int'(ptr_q) + k;
      if (c >= NREQ) c = c - NREQ;
      if (en && !found && req[c[IW-1:0]]) begin
        found              = 1'b1;
        grant[c[IW-1:0]]   = 1'b1;
        grant_idx          = c[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/mult_sched.sv
// mult_sched: shares one signed shift-add multiplier datapath between NREQ
// requesters.
//   Clk, Reset_n           - clock, asynchronous active-low reset
//   req_valid/req_ready    - per-requester request handshake (one-hot grant)
//   req_mcand/req_mplier   - packed signed operands, slice i = requester i
//   rsp_valid/rsp_ready    - product handshake
//   rsp_id, rsp_product    - requester index and signed 2*WIDTH-bit product
//   dp_S, dp_Bin           - multiplicand and multiplier load data to datapath
//   dp_LoadB .. dp_Shift   - datapath controls
//   dp_M, dp_A, dp_B       - datapath feedback (B[0], A and B registers)
//   dbg_state              - current FSM state
//
// Handshakes: a transfer happens on the rising edge where valid and ready are
// both high. A requester holds valid and operands stable until granted and may
// withdraw before that; the response side holds valid, id and product stable
// until ready is seen. req_ready depends only on state, pointer and req_valid.
module mult_sched
  import mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREQ  = DEF_NREQ
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_mcand,
  input  logic [NREQ*WIDTH-1:0]   req_mplier,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [2*WIDTH-1:0]      rsp_product,
  output logic [WIDTH-1:0]        dp_S,
  output logic [WIDTH-1:0]        dp_Bin,
  output logic                    dp_LoadB,
  output logic                    dp_ClearA,
  output logic                    dp_Add,
  output logic                    dp_Sub,
  output logic                    dp_Shift,
  input  logic                    dp_M,
  input  logic [WIDTH-1:0]        dp_A,
  input  logic [WIDTH-1:0]        dp_B,
  output logic [2:0]              dbg_state
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] op_mcand, op_mplier;
  logic [WIDTH-1:0] sel_mcand, sel_mplier;
  logic [IW-1:0]    grant_idx;
  logic             arb_en, hs, last;

  // Reset also masks the grant so req_ready reads zero while reset is held.
  assign arb_en    = (state_q == ST_IDLE) && Reset_n;
  assign hs        = |(req_valid & req_ready);
  assign last      = (cnt_q == CNT_LAST);
  assign rsp_valid = (state_q == ST_RESP);
  assign dp_S      = op_mcand;
  assign dbg_state = state_q;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .en        (arb_en),
    .req       (req_valid),
    .advance   (hs),
    .grant     (req_ready),
    .grant_idx (grant_idx)
  );

  always_comb begin
    sel_mcand  = '0;
    sel_mplier = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        sel_mcand  = req_mcand[i*WIDTH +: WIDTH];
        sel_mplier = req_mplier[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      op_mcand    <= '0;
      op_mplier   <= '0;
      rsp_id      <= '0;
      rsp_product <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (hs) begin
        op_mcand  <= sel_mcand;
        op_mplier <= sel_mplier;
        rsp_id    <= grant_idx;
      end
      if (state_q == ST_CAPTURE) begin
        rsp_product <= {dp_A, dp_B};
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dp_LoadB  = 1'b0;
    dp_ClearA = 1'b0;
    dp_Add    = 1'b0;
    dp_Sub    = 1'b0;
    dp_Shift  = 1'b0;
    dp_Bin    = '0;
    case (state_q)
      ST_IDLE: begin
        if (hs) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        dp_LoadB  = 1'b1;
        dp_ClearA = 1'b1;
        dp_Bin    = op_mplier;
        cnt_d     = '0;
        state_d   = ST_ADD;
      end
      ST_ADD: begin
        // The sign bit of the multiplier carries negative weight, so the
        // final iteration subtracts (Add and Sub both high).
        dp_Add  = dp_M;
        dp_Sub  = dp_M & last;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        dp_Shift = 1'b1;
        if (last) begin
          state_d = ST_CAPTURE;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = ST_ADD;
        end
      end
      ST_CAPTURE: begin
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mult_sched.sv
// tb_mult_sched: self-checking bench for mult_sched with a behavioural model
// of the shift-add datapath, a round-robin grant model and a product
// scoreboard.
module tb_mult_sched;
  import mult_pkg::*;

  localparam int W    = 8;
  localparam int NREQ = 2;
  localparam int IW   = 1;
  localparam int RW   = IW + 2 * W;

  // ---------------- clock / reset ----------------
  logic Clk = 1'b0;
  always #5 Clk = ~Clk;
  logic Reset_n = 1'b0;

  // ---------------- DUT signals ----------------
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_mcand = '0;
  logic [NREQ*W-1:0] req_mplier = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic [IW-1:0]     rsp_id;
  logic [2*W-1:0]    rsp_product;
  logic [W-1:0]      dp_S, dp_Bin;
  logic              dp_LoadB, dp_ClearA, dp_Add, dp_Sub, dp_Shift;
  logic              dp_M;
  logic [W-1:0]      dp_A, dp_B;
  logic [2:0]        dbg_state;

  mult_sched #(.WIDTH(W), .NREQ(NREQ)) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_mcand   (req_mcand),
    .req_mplier  (req_mplier),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_product (rsp_product),
    .dp_S        (dp_S),
    .dp_Bin      (dp_Bin),
    .dp_LoadB    (dp_LoadB),
    .dp_ClearA   (dp_ClearA),
    .dp_Add      (dp_Add),
    .dp_Sub      (dp_Sub),
    .dp_Shift    (dp_Shift),
    .dp_M        (dp_M),
    .dp_A        (dp_A),
    .dp_B        (dp_B),
    .dbg_state   (dbg_state)
  );

  // ---------------- datapath model ----------------
  // A is kept 9 bits wide so the adder result keeps its true sign for the
  // arithmetic right shift that follows.
  logic [W:0]   a9  = '0;
  logic [W-1:0] b_r = '0;
  assign dp_A = a9[W-1:0];
  assign dp_B = b_r;
  assign dp_M = b_r[0];

  always @(posedge Clk) begin
    if (dp_ClearA)     a9 <= '0;
    else if (dp_Add)   a9 <= dp_Sub ? a9 - {dp_S[W-1], dp_S} : a9 + {dp_S[W-1], dp_S};
    else if (dp_Shift) a9 <= {a9[W], a9[W:1]};
    if (dp_LoadB)      b_r <= dp_Bin;
    else if (dp_Shift) b_r <= {a9[0], b_r[W-1:1]};
  end

  // ---------------- checking ----------------
  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [NREQ-1:0] rr_pick(input int p, input logic [NREQ-1:0] v);
    logic [NREQ-1:0] g;
    g = '0;
    for (int k = 1; k <= NREQ; k++) begin
      int c;
      c = (p + k) % NREQ;
      if (v[c] && g == '0) g[c] = 1'b1;
    end
    return g;
  endfunction

  // ---------------- scoreboard / monitor ----------------
  logic [RW-1:0]  exp_q[$];
  int             grant_log[$];
  int             hs_cyc_log[$];
  bit             active = 0;
  int             ph = 0;
  int             ptr_m = NREQ - 1;
  int             cyc = 0;
  bit             hs_flag = 0;
  int             hs_id = 0;
  logic [W-1:0]   cur_mc = '0, cur_mp = '0;
  logic [2*W-1:0] last_prod = '0;
  int             last_id = 0;

  always @(negedge Clk) begin
    logic [4:0]      exp_ctl;
    logic [NREQ-1:0] exp_g;
    logic            e_load, e_shift, e_addst;
    logic [RW-1:0]   e;
    logic signed [2*W-1:0] p;
    int              id;
    if (!Reset_n) begin
      active  = 0;
      ph      = 0;
      ptr_m   = NREQ - 1;
      hs_flag = 0;
      exp_q.delete();
    end else begin
      if (active) ph++;
      e_load  = active && ph == 1;
      e_addst = active && ph >= 2 && ph <= 16 && ph % 2 == 0;
      e_shift = active && ph >= 3 && ph <= 17 && ph % 2 == 1;
      exp_ctl = {e_load, e_load, e_addst && dp_M, e_addst && dp_M && ph == 16, e_shift};
      check("dp_ctl", {dp_LoadB, dp_ClearA, dp_Add, dp_Sub, dp_Shift}, exp_ctl);
      check("dp_Bin", dp_Bin, e_load ? cur_mp : '0);
      check("rsp_valid", rsp_valid, active && ph >= MULT_LAT);
      if (active) begin
        check("dp_S", dp_S, cur_mc);
        check("req_ready_busy", req_ready, '0);
        if (ph >= MULT_LAT && rsp_valid && rsp_ready) begin
          if (exp_q.size() == 0) begin
            check("sb_empty", exp_q.size(), 1);
          end else begin
            e = exp_q.pop_front();
            check("rsp_id", rsp_id, e[RW-1 -: IW]);
            check("rsp_product", rsp_product, e[2*W-1:0]);
          end
          last_prod = rsp_product;
          last_id   = rsp_id;
          active    = 0;
        end
      end else begin
        exp_g = rr_pick(ptr_m, req_valid);
        check("req_ready", req_ready, exp_g);
        if (|(req_valid & req_ready)) begin
          id = 0;
          for (int i = 0; i < NREQ; i++) if (exp_g[i]) id = i;
          cur_mc = req_mcand[id*W +: W];
          cur_mp = req_mplier[id*W +: W];
          p = $signed(cur_mc) * $signed(cur_mp);
          exp_q.push_back({IW'(id), p});
          grant_log.push_back(id);
          hs_cyc_log.push_back(cyc);
          ptr_m   = id;
          active  = 1;
          ph      = 0;
          hs_flag = 1;
          hs_id   = id;
        end
      end
    end
    cyc++;
  end

  // ---------------- driver tasks ----------------
  task automatic set_ops(input int id, input logic [W-1:0] mc, input logic [W-1:0] mp);
    req_mcand[id*W +: W]  = mc;
    req_mplier[id*W +: W] = mp;
  endtask

  task automatic wait_hs(output int id);
    id = -1;
    for (int i = 0; i < 100; i++) begin
      @(posedge Clk); #1;
      if (hs_flag) begin
        hs_flag = 0;
        id = hs_id;
        return;
      end
    end
    check("hs_timeout", hs_flag, 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(posedge Clk); #1;
      if (!active) return;
    end
    check("done_timeout", active, 0);
  endtask

  task automatic do_op(input int id, input logic [W-1:0] mc, input logic [W-1:0] mp);
    int g;
    set_ops(id, mc, mp);
    req_valid[id] = 1'b1;
    wait_hs(g);
    req_valid[id] = 1'b0;
    wait_idle();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_req_ready"}, req_ready, '0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_id"}, rsp_id, '0);
    check({tag, "_rsp_product"}, rsp_product, '0);
    check({tag, "_dp_ctl"}, {dp_LoadB, dp_ClearA, dp_Add, dp_Sub, dp_Shift}, '0);
    check({tag, "_dp_S"}, dp_S, '0);
    check({tag, "_dp_Bin"}, dp_Bin, '0);
    check({tag, "_state"}, dbg_state, ST_IDLE);
  endtask

  // ---------------- main sequence ----------------
  logic [W-1:0]   c_mc [5] = '{8'h07, 8'h80, 8'hFF, 8'h00, 8'h7F};
  logic [W-1:0]   c_mp [5] = '{8'hFD, 8'h80, 8'h02, 8'h9C, 8'h7F};
  logic [2*W-1:0] c_pr [5] = '{16'hFFEB, 16'h4000, 16'hFFFE, 16'h0000, 16'h3F01};

  initial begin
    int g, n, g0;
    logic [2*W-1:0] snap_p;
    logic [IW-1:0]  snap_id;

    // Reset with requests pending: everything must stay quiet.
    req_valid = 2'b11;
    req_mcand = 16'h1234;
    repeat (3) @(posedge Clk);
    #1;
    check_zero("reset");
    req_valid = '0;
    req_mcand = '0;
    Reset_n   = 1'b1;
    @(posedge Clk); #1;

    // Single requests with corner operands from requester 0.
    for (int i = 0; i < 5; i++) begin
      do_op(0, c_mc[i], c_mp[i]);
      check("corner_prod", last_prod, c_pr[i]);
      check("corner_id", last_id, 0);
    end

    // Backpressure on a requester-1 product while requester 0 waits.
    rsp_ready = 1'b0;
    set_ops(1, 8'hA5, 8'h3C);
    req_valid = 2'b10;
    wait_hs(g);
    req_valid = '0;
    for (int i = 0; i < 40 && !rsp_valid; i++) begin
      @(posedge Clk); #1;
    end
    check("bp_rsp_valid", rsp_valid, 1);
    snap_p  = rsp_product;
    snap_id = rsp_id;
    check("bp_id", snap_id, 1);
    req_valid = 2'b01;
    repeat (10) begin
      @(posedge Clk); #1;
      check("bp_hold_valid", rsp_valid, 1);
      check("bp_hold_prod", rsp_product, snap_p);
      check("bp_hold_id", rsp_id, snap_id);
      check("bp_req_ready", req_ready, '0);
    end
    rsp_ready = 1'b1;
    req_valid = '0;
    @(posedge Clk); #1;
    check("bp_release_valid", rsp_valid, 0);
    check("bp_release_state", dbg_state, ST_IDLE);

    // Contention: both requesters held valid, fresh operands after each grant.
    g0 = grant_log.size();
    set_ops(0, W'($urandom_range(0, 255)), W'($urandom_range(0, 255)));
    set_ops(1, W'($urandom_range(0, 255)), W'($urandom_range(0, 255)));
    req_valid = 2'b11;
    n = 0;
    for (int i = 0; i < 200 && n < 4; i++) begin
      @(posedge Clk); #1;
      if (hs_flag) begin
        hs_flag = 0;
        set_ops(hs_id, W'($urandom_range(0, 255)), W'($urandom_range(0, 255)));
        n++;
      end
    end
    req_valid = '0;
    wait_idle();
    check("cont_grants", grant_log.size() - g0, 4);
    if (grant_log.size() >= g0 + 4) begin
      for (int k = 0; k < 4; k++) check("cont_order", grant_log[g0+k], k % 2);
      for (int k = 1; k < 4; k++) check("cont_interval", hs_cyc_log[g0+k] - hs_cyc_log[g0+k-1], 20);
    end

    // Random single operations from either requester.
    for (int i = 0; i < 6; i++) begin
      do_op(int'($urandom_range(0, 1)), W'($urandom_range(0, 255)), W'($urandom_range(0, 255)));
    end

    // Reset during the SHIFT with cnt=3 (cycle 9 after the handshake).
    set_ops(0, 8'h5A, 8'hC3);
    req_valid = 2'b01;
    wait_hs(g);
    req_valid = '0;
    repeat (8) @(posedge Clk);
    #1;
    check("mid_state", dbg_state, ST_SHIFT);
    check("mid_shift", dp_Shift, 1);
    req_valid = 2'b11;
    Reset_n   = 1'b0;
    #1;
    check_zero("mid_reset");
    repeat (2) @(posedge Clk);
    #1;
    check_zero("mid_reset_hold");
    Reset_n = 1'b1;
    // Requester 0 was the last winner, so only a cleared pointer serves it first.
    wait_hs(g);
    check("post_rst_first", g, 0);
    req_valid[0] = 1'b0;
    wait_hs(g);
    check("post_rst_second", g, 1);
    req_valid = '0;
    wait_idle();

    check("sb_leftover", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mult_sched.md
# mult_sched

Scheduler that shares one signed shift-add multiplier datapath (A/B/X registers, 9-bit adder/subtractor) between `NREQ` requesters. It arbitrates round-robin, latches the winner's operands, and sequences the datapath through load, eight add/shift iterations and a final subtract. It returns the 2·WIDTH-bit product with the requester ID over a valid/ready response port. It sits between the requesting front-end logic and the multiplier datapath, replacing per-requester hardwired control.

## Interface
- `WIDTH`, 8: operand width; the product is 2·WIDTH bits.
- `NREQ`, 2: number of requesters, at least 2.

- `Clk`  in  1  single clock; everything is on the rising edge.
- `Reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NREQ  per-requester request.
- `req_ready`  out  NREQ  one-hot grant; the handshake completes when valid & ready.
- `req_mcand`  in  NREQ·WIDTH  packed signed multiplicands; slice i belongs to requester i.
- `req_mplier`  in  NREQ·WIDTH  packed signed multipliers.
- `rsp_valid`  out  1  product available.
- `rsp_ready`  in  1  consumer accepts the product.
- `rsp_id`  out  $clog2(NREQ)  requester index of the product.
- `rsp_product`  out  2·WIDTH  signed product.
- `dp_S`  out  WIDTH  multiplicand to the adder, held for the whole operation.
- `dp_Bin`  out  WIDTH  multiplier parallel-load data.
- `dp_LoadB`, `dp_ClearA`, `dp_Add`, `dp_Sub`, `dp_Shift`  out  1 each  datapath controls.
- `dp_M`  in  1  B[0] from the datapath.
- `dp_A`, `dp_B`  in  WIDTH each  datapath register contents.

## Operation
- **States:** IDLE, LOAD, ADD, SHIFT, CAPTURE, RESP. A 3-bit iteration counter `cnt` runs from 0 to WIDTH−1.
- **IDLE:**
  - `req_ready` is the round-robin winner among the asserted `req_valid` bits. It is all-zero if no request is valid.
  - On the handshake, latch the winner's operands into `op_mcand`/`op_mplier`, record the ID, advance the pointer to the winner, and go to LOAD.
- **LOAD:** drive `dp_LoadB=1`, `dp_ClearA=1` and `dp_Bin=op_mplier`. Clear `cnt` to 0 and go to ADD.
- **ADD:**
  - `dp_Add = dp_M`.
  - `dp_Sub = dp_M & (cnt==WIDTH−1)`. The last iteration subtracts, so `Add` and `Sub` are both high when a subtract is needed.
  - Go to SHIFT.
- **SHIFT:** drive `dp_Shift=1`.
  - If `cnt==WIDTH−1`, go to CAPTURE.
  - Otherwise increment `cnt` and go to ADD.
- **CAPTURE:** register `rsp_product <= {dp_A, dp_B}` and go to RESP.
- **RESP:** hold `rsp_valid=1` with a stable product and ID. On `rsp_ready`, go to IDLE.
- **Datapath controls:** all are 0 in every state not listed for them.
- **`dp_S` / `dp_Bin`:** `dp_S = op_mcand` at all times. `dp_Bin` is 0 outside LOAD.
- **Arbitration:**
  - Search starts at pointer+1, mod NREQ.
  - The reset value of the pointer is NREQ−1, so requester 0 has first priority.
  - The pointer changes only on an accepted handshake.
- **Requester obligations:** hold `req_valid` and operands until granted. Deasserting `req_valid` before the grant is legal, and that requester is not served.
- **Simultaneous requests:** exactly one `req_ready` bit is high. The other requesters wait at least one full operation.
- **Arithmetic:** signed two's complement. The result is exact for all 2^(2·WIDTH) operand pairs, including −2^(WIDTH−1) × −2^(WIDTH−1).
- **Reset at any time, including mid-operation:**
  - State goes to IDLE; `cnt`, operands, ID, product and pointer are cleared, with the pointer set to NREQ−1.
  - All outputs go to 0: `req_ready`, `rsp_valid`, `rsp_id`, `rsp_product`, `dp_*`.
  - The datapath contents are don't-care until the next LOAD.

## Timing
- The handshake happens in cycle 0.
  - LOAD is cycle 1.
  - ADD/SHIFT pairs occupy cycles 2–17.
  - CAPTURE is cycle 18.
  - `rsp_valid` first rises in cycle 19.
- With `rsp_ready` held high, the next grant can occur in cycle 20. Back-to-back throughput is one product per 20 cycles.
- `req_ready` is combinational from state, pointer and `req_valid`; there is no combinational path from `rsp_ready` to `req_ready`.
- `rsp_valid`/`rsp_product`/`rsp_id` are registered and stable while stalled. Backpressure stalls indefinitely in RESP with the datapath idle.

## Structure
- **Package `mult_pkg`:** state enum typedef (`logic [2:0]`), default `WIDTH`/`NREQ` constants, and the latency constant `MULT_LAT = 2·WIDTH+3`.
- **Sub-module `rr_arbiter`:** NREQ-wide round-robin arbiter with its own pointer register and an `advance` input. The top-level FSM and counter live in `mult_sched`.

## Test plan
- **Single request:** req0 with 8'h07 × 8'hFD → `rsp_valid` in cycle 19, `rsp_product`=16'hFFEB, `rsp_id`=0.
- **Corner operands:**
  - 8'h80 × 8'h80 → 16'h4000.
  - 8'hFF × 8'h02 → 16'hFFFE.
  - 8'h00 × 8'h9C → 16'h0000.
  - 8'h7F × 8'h7F → 16'h3F01.
- **Contention:** req0 and req1 held valid continuously → grants alternate 0,1,0,1; products match a reference model; one accept per 20 cycles.
- **Backpressure:** `rsp_ready` low for 10 cycles in RESP → outputs stable, no `dp_*` activity, `req_ready` all-zero; release → IDLE next cycle.
- **Reset mid-operation:** assert `Reset_n` low during SHIFT with cnt=3 → all outputs 0 immediately. After release, req1 is served first only if req0 is absent (pointer reset check).
- **Control sequence check:** per operation, exactly 1 `dp_LoadB`, 8 `dp_Shift` pulses, `dp_Sub` only in the final ADD, and `dp_Add` matching `dp_M` in each ADD.
